// File: rtl/exe_muldiv_pkg.sv
// exe_muldiv_pkg: shared constants, state encoding and operand-decode helpers
// for the RV32M multi-cycle execute unit (exe_muldiv).
package exe_muldiv_pkg;

   // funct7 value that selects the M extension within R-type instructions
   localparam logic [6:0] INST_M_FUNCT7 = 7'b0000001;

   // funct3 encodings of the M-extension operations
   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   // Controller states
   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   // Divide/remainder group occupies the upper half of the funct3 space
   function automatic logic md_is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

   // rs1 is treated as signed for MULH, MULHSU, DIV and REM
   function automatic logic md_op1_signed(input logic [2:0] f3);
      return (f3 == MD_MULH) || (f3 == MD_MULHSU) || (f3 == MD_DIV) || (f3 == MD_REM);
   endfunction

   // rs2 is treated as signed for MULH, DIV and REM only
   function automatic logic md_op2_signed(input logic [2:0] f3);
      return (f3 == MD_MULH) || (f3 == MD_DIV) || (f3 == MD_REM);
   endfunction

endpackage

// File: rtl/exe_muldiv_step.sv
// exe_muldiv_step: purely combinational STEP-bit iteration shared by the
// multiplier (shift-add, product held as {hi,lo}) and the restoring divider
// (remainder in hi, dividend/quotient shifting through lo).
module exe_muldiv_step
   import exe_muldiv_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int STEP = 1
)(
   input  logic            is_div_i,
   input  logic [XLEN-1:0] hi_i,
   input  logic [XLEN-1:0] lo_i,
   input  logic [XLEN-1:0] opnd_i,
   output logic [XLEN-1:0] hi_o,
   output logic [XLEN-1:0] lo_o
);

   // Per-bit chain: element 0 is the register value, element STEP the result
   logic [XLEN-1:0] hi_c [0:STEP];
   logic [XLEN-1:0] lo_c [0:STEP];

   assign hi_c[0] = hi_i;
   assign lo_c[0] = lo_i;

   genvar gi;
   generate
      for (gi = 0; gi < STEP; gi++) begin : g_bit
         logic [XLEN:0] mul_sum;
         logic [XLEN:0] div_shift;
         logic [XLEN:0] div_trial;
         logic          div_fits;

         // Multiply: add multiplicand when the current multiplier bit is set,
         // then shift {carry,hi,lo} right by one.
         assign mul_sum   = {1'b0, hi_c[gi]} + (lo_c[gi][0] ? {1'b0, opnd_i} : {(XLEN+1){1'b0}});

         // Divide: shift the next dividend bit into the partial remainder and
         // try subtracting the divisor; a clear borrow bit means it fits.
         assign div_shift = {hi_c[gi], lo_c[gi][XLEN-1]};
         assign div_trial = div_shift - {1'b0, opnd_i};
         assign div_fits  = ~div_trial[XLEN];

         assign hi_c[gi+1] = is_div_i ? (div_fits ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0])
                                      : mul_sum[XLEN:1];
         assign lo_c[gi+1] = is_div_i ? {lo_c[gi][XLEN-2:0], div_fits}
                                      : {mul_sum[0], lo_c[gi][XLEN-1:1]};
      end
   endgenerate

   assign hi_o = hi_c[STEP];
   assign lo_o = lo_c[STEP];

endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU). Iterative datapath retiring STEP bits per cycle, with
// sign correction in a dedicated FIX cycle and 1-cycle fast paths for
// divide-by-zero and signed overflow.
// Optional: define EXE_MULDIV_FAST_MUL_EN to compute all multiplies with a
// combinational multiplier in a single cycle (divide stays iterative).
module exe_muldiv
   import exe_muldiv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int STEP    = 1,
   parameter int RADDR_W = 5
)(
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic [2:0]         funct3_i,
   input  logic [XLEN-1:0]    op1_i,
   input  logic [XLEN-1:0]    op2_i,
   input  logic [RADDR_W-1:0] reg_waddr_i,
   input  logic               flush_i,
   output logic [XLEN-1:0]    result_o,
   output logic               done_o,
   output logic               reg_we_o,
   output logic [RADDR_W-1:0] reg_waddr_o,
   output logic               busy_o,
   output logic               stallreq_o
);

   localparam int               CNT_W    = $clog2(XLEN + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - STEP);
   localparam logic [CNT_W-1:0] CNT_INC  = CNT_W'(STEP);
   localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

   md_state_e          state_q,  state_d;
   logic [CNT_W-1:0]   count_q,  count_d;
   logic [2:0]         f3_q,     f3_d;
   logic               neg1_q,   neg1_d;
   logic               neg2_q,   neg2_d;
   logic [XLEN-1:0]    opnd_q,   opnd_d;
   logic [XLEN-1:0]    hi_q,     hi_d;
   logic [XLEN-1:0]    lo_q,     lo_d;
   logic [XLEN-1:0]    result_q, result_d;
   logic [RADDR_W-1:0] waddr_q,  waddr_d;

   logic               op1_neg, op2_neg;
   logic [XLEN-1:0]    op1_abs, op2_abs;
   logic               div_by_zero, div_ovf;
   logic [XLEN-1:0]    step_hi, step_lo;
   logic [XLEN-1:0]    fix_result;

   // Apply sign to a 2*XLEN magnitude and pick the low or high half
   function automatic logic [XLEN-1:0] mul_select(input logic [2:0]        f3,
                                                  input logic              negate,
                                                  input logic [2*XLEN-1:0] mag);
      logic [2*XLEN-1:0] prod;
      prod = negate ? -mag : mag;
      return (f3 == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   endfunction

   // Decode operand signs, magnitudes and the divide special cases
   always_comb begin
      op1_neg     = md_op1_signed(funct3_i) & op1_i[XLEN-1];
      op2_neg     = md_op2_signed(funct3_i) & op2_i[XLEN-1];
      op1_abs     = op1_neg ? -op1_i : op1_i;
      op2_abs     = op2_neg ? -op2_i : op2_i;
      div_by_zero = (op2_i == '0);
      div_ovf     = ~funct3_i[0] && (op1_i == MIN_NEG) && (op2_i == '1);
   end

`ifdef EXE_MULDIV_FAST_MUL_EN
   logic [XLEN-1:0] fast_result;

   // Single-cycle multiply on the operand magnitudes, then sign and select
   always_comb begin
      fast_result = mul_select(funct3_i, op1_neg ^ op2_neg,
                               {{XLEN{1'b0}}, op1_abs} * {{XLEN{1'b0}}, op2_abs});
   end
`endif

   exe_muldiv_step #(
      .XLEN (XLEN),
      .STEP (STEP)
   ) u_step (
      .is_div_i (md_is_div(f3_q)),
      .hi_i     (hi_q),
      .lo_i     (lo_q),
      .opnd_i   (opnd_q),
      .hi_o     (step_hi),
      .lo_o     (step_lo)
   );

   // Sign correction and output selection for the FIX cycle
   always_comb begin
      if (md_is_div(f3_q)) begin
         if (f3_q[1]) begin
            // Remainder follows the dividend's sign
            fix_result = neg1_q ? -hi_q : hi_q;
         end else begin
            fix_result = (neg1_q ^ neg2_q) ? -lo_q : lo_q;
         end
      end else begin
         fix_result = mul_select(f3_q, neg1_q ^ neg2_q, {hi_q, lo_q});
      end
   end

   // Next-state logic, datapath register updates and stall request
   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      f3_d       = f3_q;
      neg1_d     = neg1_q;
      neg2_d     = neg2_q;
      opnd_d     = opnd_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      result_d   = result_q;
      waddr_d    = waddr_q;
      stallreq_o = 1'b0;

      case (state_q)
         MD_IDLE: begin
            if (start_i && !flush_i) begin
               stallreq_o = 1'b1;
               f3_d       = funct3_i;
               waddr_d    = reg_waddr_i;
               neg1_d     = op1_neg;
               neg2_d     = op2_neg;
               count_d    = '0;
               hi_d       = '0;
               if (md_is_div(funct3_i)) begin
                  opnd_d = op2_abs;
                  lo_d   = op1_abs;
                  if (div_by_zero) begin
                     result_d = funct3_i[1] ? op1_i : '1;
                     state_d  = MD_DONE;
                  end else if (div_ovf) begin
                     result_d = funct3_i[1] ? '0 : op1_i;
                     state_d  = MD_DONE;
                  end else begin
                     state_d  = MD_CALC;
                  end
               end else begin
`ifdef EXE_MULDIV_FAST_MUL_EN
                  result_d = fast_result;
                  state_d  = MD_DONE;
`else
                  opnd_d   = op1_abs;
                  lo_d     = op2_abs;
                  state_d  = MD_CALC;
`endif
               end
            end
         end

         MD_CALC: begin
            stallreq_o = 1'b1;
            if (flush_i) begin
               state_d = MD_IDLE;
            end else begin
               hi_d    = step_hi;
               lo_d    = step_lo;
               count_d = count_q + CNT_INC;
               if (count_q == CNT_LAST) begin
                  state_d = MD_FIX;
               end
            end
         end

         MD_FIX: begin
            stallreq_o = 1'b1;
            if (flush_i) begin
               state_d = MD_IDLE;
            end else begin
               result_d = fix_result;
               state_d  = MD_DONE;
            end
         end

         MD_DONE: begin
            // The write-back always completes, even under flush
            state_d = MD_IDLE;
         end

         default: begin
            state_d = MD_IDLE;
         end
      endcase
   end

   // State and datapath registers with asynchronous clear
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= MD_IDLE;
         count_q  <= '0;
         f3_q     <= '0;
         neg1_q   <= 1'b0;
         neg2_q   <= 1'b0;
         opnd_q   <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
         waddr_q  <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         f3_q     <= f3_d;
         neg1_q   <= neg1_d;
         neg2_q   <= neg2_d;
         opnd_q   <= opnd_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
         waddr_q  <= waddr_d;
      end
   end

   assign result_o    = result_q;
   assign done_o      = (state_q == MD_DONE);
   assign reg_we_o    = done_o;
   assign reg_waddr_o = waddr_q;
   assign busy_o      = (state_q != MD_IDLE);

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: directed, table-driven bench for exe_muldiv plus hand-written
// flush / reset / busy-start sequences. Define EXE_MULDIV_FAST_MUL_EN for the
// fast-multiply build; change STEP to exercise other step widths.
module tb_exe_muldiv;

   localparam int XLEN    = 32;
   localparam int STEP    = 1;
   localparam int RADDR_W = 5;
   localparam int NLAT    = XLEN / STEP + 2;
   localparam int MAX_CYC = 200;

   localparam logic [2:0] F_MUL    = 3'd0;
   localparam logic [2:0] F_MULH   = 3'd1;
   localparam logic [2:0] F_MULHSU = 3'd2;
   localparam logic [2:0] F_MULHU  = 3'd3;
   localparam logic [2:0] F_DIV    = 3'd4;
   localparam logic [2:0] F_DIVU   = 3'd5;
   localparam logic [2:0] F_REM    = 3'd6;
   localparam logic [2:0] F_REMU   = 3'd7;

   logic               clk_i = 1'b0;
   logic               rst_n_i;
   logic               start_i;
   logic [2:0]         funct3_i;
   logic [XLEN-1:0]    op1_i;
   logic [XLEN-1:0]    op2_i;
   logic [RADDR_W-1:0] reg_waddr_i;
   logic               flush_i;
   logic [XLEN-1:0]    result_o;
   logic               done_o;
   logic               reg_we_o;
   logic [RADDR_W-1:0] reg_waddr_o;
   logic               busy_o;
   logic               stallreq_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk_i = ~clk_i;

   exe_muldiv #(
      .XLEN    (XLEN),
      .STEP    (STEP),
      .RADDR_W (RADDR_W)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .start_i     (start_i),
      .funct3_i    (funct3_i),
      .op1_i       (op1_i),
      .op2_i       (op2_i),
      .reg_waddr_i (reg_waddr_i),
      .flush_i     (flush_i),
      .result_o    (result_o),
      .done_o      (done_o),
      .reg_we_o    (reg_we_o),
      .reg_waddr_o (reg_waddr_o),
      .busy_o      (busy_o),
      .stallreq_o  (stallreq_o)
   );

   typedef struct {
      string       name;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  wa;
      logic [31:0] exp;
      bit          special;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%08h), required %0d (0x%08h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic int lat_for(input logic [2:0] f3, input bit special);
      if (special) return 1;
`ifdef EXE_MULDIV_FAST_MUL_EN
      if (!f3[2]) return 1;
`endif
      return NLAT;
   endfunction

   // Issue one operation at the current negedge and follow it to completion.
   // poke_at > 0 raises start_i with unrelated operands in that busy cycle.
   task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa,
                         input logic [31:0] exp, input int exp_lat, input int poke_at);
      int lat    = 1;
      int stalls = 0;
      funct3_i    = f3;
      op1_i       = a;
      op2_i       = b;
      reg_waddr_i = wa;
      flush_i     = 1'b0;
      start_i     = 1'b1;
      #1;
      check({nm, " stall@start"}, 32'(stallreq_o), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
      while (!done_o && lat < MAX_CYC) begin
         if (stallreq_o) stalls++;
         if (lat == poke_at) begin
            start_i     = 1'b1;
            funct3_i    = F_MUL;
            op1_i       = 32'd5;
            op2_i       = 32'd6;
            reg_waddr_i = 5'd31;
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk_i);
         lat++;
      end
      start_i = 1'b0;
      if (!done_o) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: no done_o within %0d cycles, required latency %0d", nm, lat, exp_lat);
      end else begin
         check({nm, " latency"},   32'(lat),         32'(exp_lat));
         check({nm, " result"},    result_o,         exp);
         check({nm, " reg_we"},    32'(reg_we_o),    32'd1);
         check({nm, " waddr"},     32'(reg_waddr_o), 32'(wa));
         check({nm, " stall@done"}, 32'(stallreq_o), 32'd0);
         check({nm, " stall cycles"}, 32'(stalls),   32'(exp_lat - 1));
      end
      @(negedge clk_i);
      check({nm, " done pulse"}, 32'(done_o), 32'd0);
      check({nm, " idle after"}, 32'(busy_o), 32'd0);
      check({nm, " result hold"}, result_o,   exp);
      $display("op %-24s f3=%0d a=0x%08h b=0x%08h -> 0x%08h latency %0d", nm, f3, a, b, result_o, lat);
   endtask

   // Start an operation and return at the negedge of the first busy cycle
   task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] wa);
      funct3_i    = f3;
      op1_i       = a;
      op2_i       = b;
      reg_waddr_i = wa;
      start_i     = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      start_i = 1'b0;
   endtask

   initial begin
      bit seen;
      rst_n_i     = 1'b0;
      start_i     = 1'b0;
      flush_i     = 1'b0;
      funct3_i    = '0;
      op1_i       = '0;
      op2_i       = '0;
      reg_waddr_i = '0;

      vecs.push_back('{"DIVU 100/7",        F_DIVU,   32'd100,        32'd7,          5'd11, 32'd14,         1'b0});
      vecs.push_back('{"REMU 100/7",        F_REMU,   32'd100,        32'd7,          5'd12, 32'd2,          1'b0});
      vecs.push_back('{"DIV -7/2",          F_DIV,    32'hFFFF_FFF9,  32'd2,          5'd1,  32'hFFFF_FFFD,  1'b0});
      vecs.push_back('{"REM -7/2",          F_REM,    32'hFFFF_FFF9,  32'd2,          5'd2,  32'hFFFF_FFFF,  1'b0});
      vecs.push_back('{"DIV 7/-2",          F_DIV,    32'd7,          32'hFFFF_FFFE,  5'd3,  32'hFFFF_FFFD,  1'b0});
      vecs.push_back('{"REM 7/-2",          F_REM,    32'd7,          32'hFFFF_FFFE,  5'd4,  32'd1,          1'b0});
      vecs.push_back('{"DIV 10/-1",         F_DIV,    32'd10,         32'hFFFF_FFFF,  5'd5,  32'hFFFF_FFF6,  1'b0});
      vecs.push_back('{"DIVU max/1",        F_DIVU,   32'hFFFF_FFFF,  32'd1,          5'd6,  32'hFFFF_FFFF,  1'b0});
      vecs.push_back('{"DIVU 0/5",          F_DIVU,   32'd0,          32'd5,          5'd8,  32'd0,          1'b0});
      vecs.push_back('{"MULHSU -1*2",       F_MULHSU, 32'hFFFF_FFFF,  32'd2,          5'd9,  32'hFFFF_FFFF,  1'b0});
      vecs.push_back('{"MULHSU min*2^31",   F_MULHSU, 32'h8000_0000,  32'h8000_0000,  5'd10, 32'hC000_0000,  1'b0});
      vecs.push_back('{"DIV x/0",           F_DIV,    32'h1234_5678,  32'd0,          5'd13, 32'hFFFF_FFFF,  1'b1});
      vecs.push_back('{"REM x/0",           F_REM,    32'h1234_5678,  32'd0,          5'd14, 32'h1234_5678,  1'b1});
      vecs.push_back('{"DIVU 5/0",          F_DIVU,   32'd5,          32'd0,          5'd15, 32'hFFFF_FFFF,  1'b1});
      vecs.push_back('{"REMU 5/0",          F_REMU,   32'd5,          32'd0,          5'd16, 32'd5,          1'b1});
      vecs.push_back('{"DIV min/-1",        F_DIV,    32'h8000_0000,  32'hFFFF_FFFF,  5'd17, 32'h8000_0000,  1'b1});
      vecs.push_back('{"REM min/-1",        F_REM,    32'h8000_0000,  32'hFFFF_FFFF,  5'd18, 32'd0,          1'b1});
      vecs.push_back('{"MUL max*max",       F_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd11, 32'd1,          1'b0});
      vecs.push_back('{"MULHU max*max",     F_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd19, 32'hFFFF_FFFE,  1'b0});
      vecs.push_back('{"MULH min*min",      F_MULH,   32'h8000_0000,  32'h8000_0000,  5'd20, 32'h4000_0000,  1'b0});
      vecs.push_back('{"MULH -1*-1",        F_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd21, 32'd0,          1'b0});
      vecs.push_back('{"MULH min*maxpos",   F_MULH,   32'h8000_0000,  32'h7FFF_FFFF,  5'd22, 32'hC000_0000,  1'b0});
      vecs.push_back('{"MUL -3*5",          F_MUL,    32'hFFFF_FFFD,  32'd5,          5'd23, 32'hFFFF_FFF1,  1'b0});

      // Reset state
      repeat (3) @(negedge clk_i);
      check("reset result",   result_o,          32'd0);
      check("reset done",     32'(done_o),       32'd0);
      check("reset reg_we",   32'(reg_we_o),     32'd0);
      check("reset waddr",    32'(reg_waddr_o),  32'd0);
      check("reset busy",     32'(busy_o),       32'd0);
      check("reset stallreq", 32'(stallreq_o),   32'd0);
      rst_n_i = 1'b1;
      @(negedge clk_i);

      // Table-driven vectors
      foreach (vecs[i]) begin
         run_op(vecs[i].name, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].wa,
                vecs[i].exp, lat_for(vecs[i].f3, vecs[i].special), 0);
      end

      // start_i raised while busy must be ignored
      run_op("DIVU 100/7 busy-start", F_DIVU, 32'd100, 32'd7, 5'd24, 32'd14, NLAT, 5);

      // Flush during CALC: no write-back, idle next cycle, next op accepted
      seen = 1'b0;
      launch(F_DIVU, 32'd1000, 32'd3, 5'd7);
      for (int c = 1; c < 10; c++) begin
         if (done_o || reg_we_o) seen = 1'b1;
         @(negedge clk_i);
      end
      check("flush calc busy before", 32'(busy_o), 32'd1);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      if (done_o || reg_we_o) seen = 1'b1;
      check("flush calc no done", 32'(seen),       32'd0);
      check("flush calc busy",    32'(busy_o),     32'd0);
      check("flush calc stall",   32'(stallreq_o), 32'd0);
      $display("seq flush during CALC at cycle 10");
      run_op("MUL 3*4 after flush", F_MUL, 32'd3, 32'd4, 5'd9, 32'd12, lat_for(F_MUL, 1'b0), 0);

      // Flush during FIX: also discarded
      seen = 1'b0;
      launch(F_DIVU, 32'd50, 32'd5, 5'd25);
      for (int c = 1; c < NLAT - 1; c++) begin
         if (done_o || reg_we_o) seen = 1'b1;
         @(negedge clk_i);
      end
      check("flush fix stall", 32'(stallreq_o), 32'd1);
      flush_i = 1'b1;
      @(negedge clk_i);
      flush_i = 1'b0;
      if (done_o || reg_we_o) seen = 1'b1;
      @(negedge clk_i);
      if (done_o || reg_we_o) seen = 1'b1;
      check("flush fix no done",  32'(seen),   32'd0);
      check("flush fix busy",     32'(busy_o), 32'd0);
      check("flush fix result",   result_o,    32'd12);
      $display("seq flush during FIX");

      // Flush in IDLE blocks start
      funct3_i = F_DIVU;
      op1_i    = 32'd8;
      op2_i    = 32'd2;
      start_i  = 1'b1;
      flush_i  = 1'b1;
      #1;
      check("idle flush stall", 32'(stallreq_o), 32'd0);
      @(negedge clk_i);
      start_i = 1'b0;
      flush_i = 1'b0;
      check("idle flush busy",  32'(busy_o),     32'd0);
      $display("seq start blocked by flush in IDLE");

      // Asynchronous reset in the middle of CALC
      launch(F_DIVU, 32'd77, 32'd5, 5'd13);
      repeat (5) @(negedge clk_i);
      check("pre-reset busy", 32'(busy_o), 32'd1);
      #2 rst_n_i = 1'b0;
      #1;
      check("async reset result",   result_o,         32'd0);
      check("async reset done",     32'(done_o),      32'd0);
      check("async reset reg_we",   32'(reg_we_o),    32'd0);
      check("async reset waddr",    32'(reg_waddr_o), 32'd0);
      check("async reset busy",     32'(busy_o),      32'd0);
      check("async reset stallreq", 32'(stallreq_o),  32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      $display("seq asynchronous reset mid-CALC");
      run_op("DIVU 9/3 after reset", F_DIVU, 32'd9, 32'd3, 5'd4, 32'd3, NLAT, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
